// File: rtl/pixel_pos.sv
// Serpentine pixel-coordinate generator: walks a max_x-by-max_y frame row by row, alternating direction.
// Optional build macro PIXEL_POS_WRAP_EN: update_pos in DONE restarts the same frame from (0,0).
module pixel_pos #(
    parameter int X_MAX = 7,
    parameter int Y_MAX = 8,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          update_pos,
    input  logic          new_trans,
    input  logic [XW-1:0] max_x,
    input  logic [YW-1:0] max_y,
    output logic          end_pos,
    output logic [1:0]    next_dir,
    output logic [XW-1:0] curr_x,
    output logic [YW-1:0] curr_y
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_NONE  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] mx_q, mx_d;
    logic [YW-1:0] my_q, my_d;
    logic          end_q, end_d;

    logic [XW-1:0] x_last;
    logic [YW-1:0] y_last;
    logic          row_odd;
    logic          at_row_end;
    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic          step_final;
    logic          new_single;

    // Only meaningful in SCAN, where the latched dims are at least 1 in each axis.
    assign x_last     = mx_q - XW'(1);
    assign y_last     = my_q - YW'(1);
    assign row_odd    = y_q[0];
    assign at_row_end = row_odd ? (x_q == '0) : (x_q == x_last);

    // A frame of zero area or a single pixel is finished as soon as it starts.
    assign new_single = (max_x == '0) || (max_y == '0) ||
                        ((max_x == XW'(1)) && (max_y == YW'(1)));

    always_comb begin
        step_x = x_q;
        step_y = y_q;
        if (at_row_end) begin
            step_y = y_q + YW'(1);
        end else if (row_odd) begin
            step_x = x_q - XW'(1);
        end else begin
            step_x = x_q + XW'(1);
        end
    end

    // The last row's parity decides which end of it holds the final pixel.
    assign step_final = (step_y == y_last) &&
                        (step_x == (y_last[0] ? XW'(0) : x_last));

`ifdef PIXEL_POS_WRAP_EN
    logic frame_single;
    assign frame_single = (mx_q == '0) || (my_q == '0) ||
                          ((mx_q == XW'(1)) && (my_q == YW'(1)));
`endif

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mx_d    = mx_q;
        my_d    = my_q;
        end_d   = end_q;

        if (new_trans) begin
            mx_d    = max_x;
            my_d    = max_y;
            x_d     = '0;
            y_d     = '0;
            end_d   = new_single;
            state_d = new_single ? S_DONE : S_SCAN;
        end else begin
            case (state_q)
                S_SCAN: begin
                    if (update_pos) begin
                        x_d = step_x;
                        y_d = step_y;
                        if (step_final) begin
                            end_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
`ifdef PIXEL_POS_WRAP_EN
                    if (update_pos && !frame_single) begin
                        x_d     = '0;
                        y_d     = '0;
                        end_d   = 1'b0;
                        state_d = S_SCAN;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_SCAN:  next_dir = at_row_end ? DIR_DOWN : (row_odd ? DIR_LEFT : DIR_RIGHT);
`ifdef PIXEL_POS_WRAP_EN
            S_DONE:  next_dir = DIR_DOWN;
`else
            S_DONE:  next_dir = DIR_NONE;
`endif
            default: next_dir = DIR_NONE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge (synchronous).
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            end_q   <= end_d;
        end
    end

    assign curr_x  = x_q;
    assign curr_y  = y_q;
    assign end_pos = end_q;

endmodule

// File: tb/tb_pixel_pos.sv
// Self-checking bench for pixel_pos: an index-based serpentine model (pixel k of a WxH frame)
// predicts curr_x/curr_y/end_pos/next_dir every cycle for directed and random stimulus.
module tb_pixel_pos;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       update_pos = 1'b0;
    logic       new_trans = 1'b0;
    logic [2:0] max_x = '0;
    logic [2:0] max_y = '0;
    logic       end_pos;
    logic [1:0] next_dir;
    logic [2:0] curr_x;
    logic [2:0] curr_y;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = idle, 1 = scanning, 2 = done; k = linear index along the serpentine path.
    int m_mode = 0;
    int m_k = 0;
    int m_w = 0;
    int m_h = 0;

    logic [2:0] exp_x;
    logic [2:0] exp_y;
    logic       exp_end;
    logic [1:0] exp_dir;

`ifdef PIXEL_POS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    pixel_pos #(.X_MAX(7), .Y_MAX(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .update_pos (update_pos),
        .new_trans  (new_trans),
        .max_x      (max_x),
        .max_y      (max_y),
        .end_pos    (end_pos),
        .next_dir   (next_dir),
        .curr_x     (curr_x),
        .curr_y     (curr_y)
    );

    always #5 clk = ~clk;

    function automatic int pos_y(input int k, input int w);
        return k / w;
    endfunction

    function automatic int pos_x(input int k, input int w);
        int row = k / w;
        int col = k % w;
        return (row % 2 == 0) ? col : (w - 1 - col);
    endfunction

    task automatic model_expect();
        int n = m_w * m_h;
        case (m_mode)
            1: begin
                exp_x   = 3'(pos_x(m_k, m_w));
                exp_y   = 3'(pos_y(m_k, m_w));
                exp_end = 1'b0;
                if (pos_y(m_k + 1, m_w) > pos_y(m_k, m_w))      exp_dir = 2'b10;
                else if (pos_x(m_k + 1, m_w) > pos_x(m_k, m_w)) exp_dir = 2'b00;
                else                                            exp_dir = 2'b01;
            end
            2: begin
                exp_x   = (n == 0) ? 3'd0 : 3'(pos_x(n - 1, m_w));
                exp_y   = (n == 0) ? 3'd0 : 3'(pos_y(n - 1, m_w));
                exp_end = 1'b1;
                exp_dir = WRAP ? 2'b10 : 2'b11;
            end
            default: begin
                exp_x   = 3'd0;
                exp_y   = 3'd0;
                exp_end = 1'b0;
                exp_dir = 2'b11;
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and settle 1 time unit later.
    task automatic tick(input bit rst_n, input bit nt, input bit up,
                        input logic [2:0] mx, input logic [2:0] my);
        n_rst      = rst_n;
        new_trans  = nt;
        update_pos = up;
        max_x      = mx;
        max_y      = my;
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_k = 0; m_w = 0; m_h = 0;
        end else if (nt) begin
            m_w = int'(mx);
            m_h = int'(my);
            m_k = 0;
            m_mode = (m_w * m_h <= 1) ? 2 : 1;
        end else if (m_mode == 1 && up) begin
            m_k++;
            if (m_k == m_w * m_h - 1) m_mode = 2;
        end else if (m_mode == 2 && up && WRAP && m_w * m_h > 1) begin
            m_k = 0;
            m_mode = 1;
        end
        model_expect();
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        checks++;
        if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b0, 2'b11}) begin
            errors++;
            $display("FAIL reset_initial: got x=%0d y=%0d end=%b dir=%b, expected x=0 y=0 end=0 dir=11",
                     curr_x, curr_y, end_pos, next_dir);
        end
        tick(1'b1, 1'b1, 1'b0, 3'd5, 3'd5);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b1, 3'd5, 3'd5);
        tick(1'b0, 1'b0, 1'b1, 3'd5, 3'd5);
        checks++;
        if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b0, 2'b11}) begin
            errors++;
            $display("FAIL reset_midframe: got x=%0d y=%0d end=%b dir=%b, expected x=0 y=0 end=0 dir=11",
                     curr_x, curr_y, end_pos, next_dir);
        end
    endtask

    // Start a frame and take the given number of enabled steps, checking every cycle against the model.
    task automatic run_frame(input string name, input logic [2:0] w, input logic [2:0] h, input int steps);
        tick(1'b1, 1'b1, 1'b1, w, h);
        for (int i = 0; i <= steps; i++) begin
            if (i > 0) tick(1'b1, 1'b0, 1'b1, w, h);
            checks++;
            if ({curr_x, curr_y, end_pos, next_dir} !== {exp_x, exp_y, exp_end, exp_dir}) begin
                errors++;
                $display("FAIL %s step %0d: got x=%0d y=%0d end=%b dir=%b, expected x=%0d y=%0d end=%b dir=%b",
                         name, i, curr_x, curr_y, end_pos, next_dir, exp_x, exp_y, exp_end, exp_dir);
            end
        end
    endtask

    task automatic test_frame_5x5();
        run_frame("frame5x5", 3'd5, 3'd5, 24);
        checks++;
        if ({curr_x, curr_y, end_pos} !== {3'd4, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL frame5x5_end: got x=%0d y=%0d end=%b, expected x=4 y=4 end=1",
                     curr_x, curr_y, end_pos);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b1, 3'd5, 3'd5);
            checks++;
            if ({curr_x, curr_y, end_pos, next_dir} !== {exp_x, exp_y, exp_end, exp_dir}) begin
                errors++;
                $display("FAIL frame5x5_after %0d: got x=%0d y=%0d end=%b dir=%b, expected x=%0d y=%0d end=%b dir=%b",
                         i, curr_x, curr_y, end_pos, next_dir, exp_x, exp_y, exp_end, exp_dir);
            end
        end
    endtask

    task automatic test_small_frames();
        run_frame("frame4x3", 3'd4, 3'd3, 11);
        checks++;
        if ({curr_x, curr_y, end_pos} !== {3'd3, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL frame4x3_end: got x=%0d y=%0d end=%b, expected x=3 y=2 end=1",
                     curr_x, curr_y, end_pos);
        end
        run_frame("frame4x2", 3'd4, 3'd2, 7);
        checks++;
        if ({curr_x, curr_y, end_pos} !== {3'd0, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL frame4x2_end: got x=%0d y=%0d end=%b, expected x=0 y=1 end=1",
                     curr_x, curr_y, end_pos);
        end
        run_frame("frame1x6", 3'd1, 3'd6, 5);
        run_frame("frame7x1", 3'd7, 3'd1, 6);
    endtask

    task automatic test_restart_midframe();
        run_frame("restart_pre", 3'd5, 3'd5, 17);
        checks++;
        if ({curr_x, curr_y} !== {3'd2, 3'd3}) begin
            errors++;
            $display("FAIL restart_at: got x=%0d y=%0d, expected x=2 y=3", curr_x, curr_y);
        end
        tick(1'b1, 1'b1, 1'b1, 3'd5, 3'd5);
        checks++;
        if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL restart_midframe: got x=%0d y=%0d end=%b dir=%b, expected x=0 y=0 end=0 dir=00",
                     curr_x, curr_y, end_pos, next_dir);
        end
    endtask

    task automatic test_degenerate();
        logic [7:0] wide;
        wide = 8'd240;
        tick(1'b1, 1'b1, 1'b0, wide[2:0], 3'd4);
        checks++;
        if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b1, (WRAP ? 2'b10 : 2'b11)}) begin
            errors++;
            $display("FAIL degenerate_x0: got x=%0d y=%0d end=%b dir=%b, expected x=0 y=0 end=1",
                     curr_x, curr_y, end_pos, next_dir);
        end
        tick(1'b1, 1'b1, 1'b1, 3'd3, 3'd0);
        tick(1'b1, 1'b0, 1'b1, 3'd3, 3'd0);
        checks++;
        if ({curr_x, curr_y, end_pos, next_dir} !== {exp_x, exp_y, exp_end, exp_dir}) begin
            errors++;
            $display("FAIL degenerate_y0: got x=%0d y=%0d end=%b dir=%b, expected x=%0d y=%0d end=%b dir=%b",
                     curr_x, curr_y, end_pos, next_dir, exp_x, exp_y, exp_end, exp_dir);
        end
        tick(1'b1, 1'b1, 1'b0, 3'd1, 3'd1);
        checks++;
        if ({curr_x, curr_y, end_pos} !== {3'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_pixel: got x=%0d y=%0d end=%b, expected x=0 y=0 end=1",
                     curr_x, curr_y, end_pos);
        end
    endtask

    // Dims move away from the latched values, update_pos toggles; outputs follow the latched frame only.
    task automatic test_hold_and_dims_ignored();
        tick(1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, i[0], 3'd7, 3'd7);
            checks++;
            if ({curr_x, curr_y, end_pos, next_dir} !== {exp_x, exp_y, exp_end, exp_dir}) begin
                errors++;
                $display("FAIL hold_dims %0d: got x=%0d y=%0d end=%b dir=%b, expected x=%0d y=%0d end=%b dir=%b",
                         i, curr_x, curr_y, end_pos, next_dir, exp_x, exp_y, exp_end, exp_dir);
            end
        end
    endtask

    task automatic test_done_behaviour();
        run_frame("done2x2", 3'd2, 3'd2, 3);
        tick(1'b1, 1'b0, 1'b1, 3'd2, 3'd2);
        checks++;
`ifdef PIXEL_POS_WRAP_EN
        if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL wrap_restart: got x=%0d y=%0d end=%b dir=%b, expected x=0 y=0 end=0 dir=00",
                     curr_x, curr_y, end_pos, next_dir);
        end
`else
        if ({curr_x, curr_y, end_pos, next_dir} !== {3'd0, 3'd1, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL done_hold: got x=%0d y=%0d end=%b dir=%b, expected x=0 y=1 end=1 dir=11",
                     curr_x, curr_y, end_pos, next_dir);
        end
`endif
    endtask

    task automatic test_random();
        tick(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            checks++;
            if ({curr_x, curr_y, end_pos, next_dir} !== {exp_x, exp_y, exp_end, exp_dir}) begin
                errors++;
                $display("FAIL random %0d: got x=%0d y=%0d end=%b dir=%b, expected x=%0d y=%0d end=%b dir=%b",
                         i, curr_x, curr_y, end_pos, next_dir, exp_x, exp_y, exp_end, exp_dir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_5x5();
        test_small_frames();
        test_restart_midframe();
        test_degenerate();
        test_hold_and_dims_ignored();
        test_done_behaviour();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
